median_window_ctrl: RTL and testbench

MEDIAN_WINDOW_CTRL -- requirements
Module: median_window_ctrl

---
 rtl/median_pkg.sv | 20 ++
 rtl/median_vld_delay.sv | 52 +++++
 rtl/median_window_ctrl.sv | 116 +++++++++++
 tb/tb_median_window_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared FSM encoding and width helpers for the median window controller
package median_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } med_state_t;

    // Column counter width; never narrower than one bit.
    function automatic int cw_of(input int img_w);
        return (img_w <= 2) ? 1 : $clog2(img_w);
    endfunction

    function automatic int rw_of(input int img_h);
        return (img_h <= 2) ? 1 : $clog2(img_h);
    endfunction

endpackage

// File: rtl/median_vld_delay.sv
// rtl/median_vld_delay.sv - LAT-deep delay line matching window-valid and centre coordinates to the median datapath
module median_vld_delay #(
    parameter int LAT = 3,
    parameter int RW  = 3,
    parameter int CW  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_vld,
    input  logic [RW-1:0] in_row,
    input  logic [CW-1:0] in_col,
    output logic          out_vld,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col
);

    logic [LAT-1:0] vld_q;
    logic [RW-1:0]  row_q [LAT];
    logic [CW-1:0]  col_q [LAT];

    // Coordinates are zeroed on invalid slots so the outputs read 0 between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else if (clr) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            row_q[0] <= in_vld ? in_row : '0;
            col_q[0] <= in_vld ? in_col : '0;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                row_q[i] <= row_q[i-1];
                col_q[i] <= col_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_row = row_q[LAT-1];
    assign out_col = col_q[LAT-1];

endmodule

// File: rtl/median_window_ctrl.sv
// rtl/median_window_ctrl.sv - raster scan, line-buffer and 3x3 window control for a streaming median filter
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int  IMG_W   = 640,
    parameter int  IMG_H   = 480,
    parameter int  MED_LAT = 3,
    localparam int CW      = cw_of(IMG_W),
    localparam int RW      = rw_of(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          pix_vld,
    output logic          lb_wr_en,
    output logic          lb_sel,
    output logic [CW-1:0] lb_addr,
    output logic          win_shift,
    output logic          out_vld,
    output logic [CW-1:0] out_col,
    output logic [RW-1:0] out_row,
    output logic          frame_done,
    output logic          busy
);

    localparam int DW = cw_of(MED_LAT + 1);

    med_state_t    state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          lb_sel_q;
    logic [DW-1:0] drain_cnt;

    logic running, accept, col_last, row_last, drain_last, win_vld;

    // frame_start takes priority over a coincident pixel: the old frame is being abandoned.
    assign running    = (state == ST_PRIME) || (state == ST_ACTIVE);
    assign accept     = pix_vld && running && !frame_start;
    assign col_last   = (col == CW'(IMG_W - 1));
    assign row_last   = (row == RW'(IMG_H - 1));
    assign drain_last = (drain_cnt == DW'(MED_LAT - 1));
    assign win_vld    = accept && (state == ST_ACTIVE) && (col >= CW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = ST_PRIME;
        end else begin
            case (state)
                ST_PRIME:  if (accept && col_last && row == RW'(1)) state_nxt = ST_ACTIVE;
                ST_ACTIVE: if (accept && col_last && row_last)      state_nxt = ST_DRAIN;
                ST_DRAIN:  if (drain_last)                          state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lb_wr_en   = accept;
        win_shift  = accept;
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_DRAIN) && drain_last && !frame_start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            lb_sel_q <= 1'b0;
        end else if (frame_start) begin
            col      <= '0;
            row      <= '0;
            lb_sel_q <= 1'b0;
        end else if (accept) begin
            if (col_last) begin
                col      <= '0;
                row      <= row_last ? '0 : row + RW'(1);
                lb_sel_q <= ~lb_sel_q;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  drain_cnt <= '0;
        else if (state == ST_DRAIN)  drain_cnt <= drain_cnt + DW'(1);
        else                         drain_cnt <= '0;
    end

    assign lb_sel  = lb_sel_q;
    assign lb_addr = col;

    // The window centre trails the incoming pixel by one row and one column.
    median_vld_delay #(
        .LAT (MED_LAT),
        .RW  (RW),
        .CW  (CW)
    ) u_vld_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (frame_start),
        .in_vld  (win_vld),
        .in_row  (row - RW'(1)),
        .in_col  (col - CW'(1)),
        .out_vld (out_vld),
        .out_row (out_row),
        .out_col (out_col)
    );

endmodule

// File: tb/tb_median_window_ctrl.sv
// tb/tb_median_window_ctrl.sv - randomized self-checking bench for median_window_ctrl
module tb_median_window_ctrl;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int LAT = 3;
    localparam int CW  = 3;
    localparam int RW  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_vld = 1'b0;
    logic          lb_wr_en, lb_sel, win_shift, out_vld, frame_done, busy;
    logic [CW-1:0] lb_addr, out_col;
    logic [RW-1:0] out_row;

    always #5 clk = ~clk;

    median_window_ctrl #(.IMG_W(W), .IMG_H(H), .MED_LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_vld     (pix_vld),
        .lb_wr_en    (lb_wr_en),
        .lb_sel      (lb_sel),
        .lb_addr     (lb_addr),
        .win_shift   (win_shift),
        .out_vld     (out_vld),
        .out_col     (out_col),
        .out_row     (out_row),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a frame is a raster of W*H accepted pixels counted by n; every
    // pixel at (r,c) with r>=2,c>=2 yields centre (r-1,c-1) LAT clocks later.
    typedef struct {int due; int r; int c;} out_t;
    out_t exp_q[$];
    bit   in_frame = 1'b0;
    int   n = 0;
    int   done_due = -1;
    int   pix19 = -1;
    int   pix48 = -1;
    bit   acc, e_ov, e_done;
    int   pr, pc;

    int st_cnt = 0;
    int st_first_r, st_first_c, st_first_cyc, st_last_r, st_last_c;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_lb_wr_en",   int'(lb_wr_en),   0);
            chk("rst_win_shift",  int'(win_shift),  0);
            chk("rst_lb_sel",     int'(lb_sel),     0);
            chk("rst_lb_addr",    int'(lb_addr),    0);
            chk("rst_out_vld",    int'(out_vld),    0);
            chk("rst_out_row",    int'(out_row),    0);
            chk("rst_out_col",    int'(out_col),    0);
            chk("rst_frame_done", int'(frame_done), 0);
            chk("rst_busy",       int'(busy),       0);
            in_frame = 1'b0;
            n        = 0;
            done_due = -1;
            st_cnt   = 0;
            exp_q.delete();
        end else begin
            acc = in_frame && (n < W*H) && pix_vld;
            chk("lb_wr_en",  int'(lb_wr_en),  int'(acc));
            chk("win_shift", int'(win_shift), int'(acc));
            if (acc) chk("lb_addr", int'(lb_addr), n % W);
            chk("lb_sel", int'(lb_sel), (n / W) % 2);
            chk("busy",   int'(busy),   int'(in_frame));
            e_ov = 1'b0;
            if (exp_q.size() > 0) e_ov = (exp_q[0].due == cyc);
            chk("out_vld", int'(out_vld), int'(e_ov));
            if (e_ov && out_vld) begin
                chk("out_row", int'(out_row), exp_q[0].r);
                chk("out_col", int'(out_col), exp_q[0].c);
            end
            e_done = (done_due == cyc) && !frame_start;
            chk("frame_done", int'(frame_done), int'(e_done));

            if (out_vld) begin
                if (st_cnt == 0) begin
                    st_first_r   = int'(out_row);
                    st_first_c   = int'(out_col);
                    st_first_cyc = cyc;
                end
                st_last_r = int'(out_row);
                st_last_c = int'(out_col);
                st_cnt++;
            end
            // Hand-derived figures for an 8x6 frame with three clocks of latency.
            if (frame_done) begin
                chk("frame_out_count", st_cnt, 24);
                chk("first_out_row", st_first_r, 1);
                chk("first_out_col", st_first_c, 1);
                chk("last_out_row", st_last_r, 4);
                chk("last_out_col", st_last_c, 6);
                chk("first_out_latency", st_first_cyc - pix19, 3);
                chk("frame_done_latency", cyc - pix48, 3);
            end

            if (e_ov) void'(exp_q.pop_front());
            if (frame_start) begin
                in_frame = 1'b1;
                n        = 0;
                done_due = -1;
                pix19    = -1;
                pix48    = -1;
                st_cnt   = 0;
                exp_q.delete();
            end else begin
                if (acc) begin
                    pr = n / W;
                    pc = n % W;
                    if (pr >= 2 && pc >= 2) exp_q.push_back('{cyc + LAT, pr - 1, pc - 1});
                    n++;
                    if (n == 19) pix19 = cyc;
                    if (n == W*H) begin
                        pix48    = cyc;
                        done_due = cyc + LAT;
                    end
                end
                if (done_due == cyc) begin
                    in_frame = 1'b0;
                    done_due = -1;
                end
            end
        end
    end

    task automatic start_frame();
        @(posedge clk); #1;
        frame_start = 1'b1;
        pix_vld     = 1'b0;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // mode 0: continuous, 1: alternate 1/0, 2: random with gaps
    task automatic drive(input int npix, input int mode);
        int sent = 0;
        int ph   = 0;
        logic v;
        while (sent < npix) begin
            @(posedge clk); #1;
            case (mode)
                0:       v = 1'b1;
                1:       v = (ph % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0) || ($urandom_range(0, 7) == 0);
            endcase
            if (mode == 2 && $urandom_range(0, 19) == 0) begin
                pix_vld = 1'b0;
                repeat ($urandom_range(3, 12)) @(posedge clk);
                #1;
            end
            pix_vld = v;
            if (v) sent++;
            ph++;
        end
    endtask

    task automatic idle(input int k, input logic v);
        @(posedge clk); #1;
        pix_vld = v;
        repeat (k) @(posedge clk);
        #1;
        pix_vld = 1'b0;
    endtask

    initial begin
        pix_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        pix_vld = 1'b0;

        start_frame(); drive(48, 0); idle(8, 1'b0);
        start_frame(); drive(48, 1); idle(8, 1'b0);
        start_frame(); drive(30, 0); start_frame(); drive(48, 2); idle(8, 1'b0);
        start_frame(); drive(48, 2); idle(8, 1'b1);
        start_frame(); drive(30, 1); idle(2, 1'b0); start_frame(); drive(48, 0); idle(8, 1'b0);

        start_frame(); drive(25, 0);
        @(posedge clk); #1;
        rst_n   = 1'b0;
        pix_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        pix_vld = 1'b0;
        start_frame(); drive(48, 2); idle(8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
